// File: rtl/envelope_bank.sv
// Multi-channel AY/YM-style envelope generator: CHANNELS independent envelopes, each with its own period, shape and restart.
// Latency: out is combinational from registers; the first level after a shape_we strobe is visible 1 clk later.
// Backpressure: none; free-running, and period is read live every clk.
// Optional feature macro: ENVELOPE_DONE_EN (registered end-of-envelope pulse on done; tied low otherwise).
module envelope_bank #(
    parameter int CHANNELS      = 3,
    parameter int PERIOD_BITS   = 16,
    parameter int ENVELOPE_BITS = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [CHANNELS*PERIOD_BITS-1:0]   period,
    input  logic [CHANNELS*4-1:0]             shape,
    input  logic [CHANNELS-1:0]               shape_we,
    output logic [CHANNELS*ENVELOPE_BITS-1:0] out,
    output logic [CHANNELS-1:0]               done
);

    localparam logic [ENVELOPE_BITS-1:0] LVL_MAX = '1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [PERIOD_BITS-1:0]   pc_q, pc_d;
        logic [ENVELOPE_BITS-1:0] cnt_q, cnt_d;
        logic [ENVELOPE_BITS-1:0] held_q, held_d;
        logic                     inv_q, inv_d;
        logic [3:0]               shp_q, shp_d;
        state_t                   st_q, st_d;

        logic [PERIOD_BITS-1:0]   per_w;
        logic [PERIOD_BITS-1:0]   lim_w;
        logic [3:0]               shp_in_w;
        logic                     step_w;
        logic                     hold_n_w;
        logic                     alt_n_w;
        logic [ENVELOPE_BITS-1:0] fin_w;

`ifdef ENVELOPE_DONE_EN
        logic                     done_q, done_d;
`endif

        assign per_w    = period[i*PERIOD_BITS +: PERIOD_BITS];
        assign shp_in_w = shape[i*4 +: 4];

        // Terminal count of the prescaler; period 0 is treated as period 1.
        // Using >= means a period lowered below the current count steps on the next clk.
        assign lim_w  = (per_w == '0) ? '0 : (per_w - PERIOD_BITS'(1));
        assign step_w = (st_q == ST_RUN) && (pc_q >= lim_w);

        // Shape normalisation, bit order {continue, attack, alternate, hold}.
        // Non-continue shapes always end holding 0.
        assign hold_n_w = shp_q[0] | ~shp_q[3];
        assign alt_n_w  = shp_q[3] ? shp_q[1] : shp_q[2];
        assign fin_w    = (shp_q[3] & (shp_q[2] ^ shp_q[1])) ? LVL_MAX : '0;

        // Next-state: restart strobe wins over a same-cycle step, which is dropped.
        always_comb begin
            pc_d   = pc_q;
            cnt_d  = cnt_q;
            held_d = held_q;
            inv_d  = inv_q;
            shp_d  = shp_q;
            st_d   = st_q;
`ifdef ENVELOPE_DONE_EN
            done_d = 1'b0;
`endif
            if (shape_we[i]) begin
                shp_d = shp_in_w;
                pc_d  = '0;
                cnt_d = '0;
                inv_d = ~shp_in_w[2];
                st_d  = ST_RUN;
            end else if (st_q == ST_RUN) begin
                if (step_w) begin
                    pc_d = '0;
                    if (cnt_q != LVL_MAX) begin
                        cnt_d = cnt_q + ENVELOPE_BITS'(1);
                    end else if (hold_n_w) begin
                        st_d   = ST_HOLD;
                        held_d = fin_w;
`ifdef ENVELOPE_DONE_EN
                        done_d = 1'b1;
`endif
                    end else begin
                        cnt_d = '0;
                        if (alt_n_w) begin
                            inv_d = ~inv_q;
                        end
                    end
                end else begin
                    pc_d = pc_q + PERIOD_BITS'(1);
                end
            end else begin
                pc_d = '0;
            end
        end

        // Channel state registers; reset parks the channel in HOLD at level 0.
        always_ff @(posedge clk) begin
            if (reset) begin
                pc_q   <= '0;
                cnt_q  <= '0;
                held_q <= '0;
                inv_q  <= 1'b0;
                shp_q  <= 4'b0000;
                st_q   <= ST_HOLD;
            end else begin
                pc_q   <= pc_d;
                cnt_q  <= cnt_d;
                held_q <= held_d;
                inv_q  <= inv_d;
                shp_q  <= shp_d;
                st_q   <= st_d;
            end
        end

`ifdef ENVELOPE_DONE_EN
        // One-clk pulse coinciding with the first cycle that shows the final level.
        always_ff @(posedge clk) begin
            if (reset) begin
                done_q <= 1'b0;
            end else begin
                done_q <= done_d;
            end
        end
        assign done[i] = done_q;
`else
        assign done[i] = 1'b0;
`endif

        assign out[i*ENVELOPE_BITS +: ENVELOPE_BITS] =
            (st_q == ST_HOLD) ? held_q : (inv_q ? (LVL_MAX - cnt_q) : cnt_q);
    end

endmodule

// File: tb/tb_envelope_bank.sv
// Directed bench for envelope_bank: 3-channel 4-bit instance plus a 1-channel 5-bit instance.
// Expected levels come from closed-form waveform formulas evaluated per clk after each strobe.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_envelope_bank;

    localparam int CH = 3;
    localparam int PB = 16;
    localparam int EB = 4;

`ifdef ENVELOPE_DONE_EN
    localparam bit DONE_EN = 1'b1;
`else
    localparam bit DONE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset;
    logic [CH*PB-1:0]    period;
    logic [CH*4-1:0]     shape;
    logic [CH-1:0]       shape_we;
    logic [CH*EB-1:0]    out;
    logic [CH-1:0]       done;

    logic                reset5;
    logic [15:0]         period5;
    logic [3:0]          shape5;
    logic                shape_we5;
    logic [4:0]          out5;
    logic                done5;

    envelope_bank #(
        .CHANNELS(CH), .PERIOD_BITS(PB), .ENVELOPE_BITS(EB)
    ) dut (
        .clk(clk), .reset(reset), .period(period), .shape(shape),
        .shape_we(shape_we), .out(out), .done(done)
    );

    envelope_bank #(
        .CHANNELS(1), .PERIOD_BITS(16), .ENVELOPE_BITS(5)
    ) dut5 (
        .clk(clk), .reset(reset5), .period(period5), .shape(shape5),
        .shape_we(shape_we5), .out(out5), .done(done5)
    );

    int passed = 0;
    int failed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lvl(input int ch);
        lvl = 32'(out[ch*EB +: EB]);
    endfunction

    initial begin
        int s;
        reset     = 1'b1;
        period    = '0;
        shape     = '0;
        shape_we  = '0;
        reset5    = 1'b1;
        period5   = '0;
        shape5    = '0;
        shape_we5 = 1'b0;
        tick();
        tick();
        check("reset_out", 32'(out), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        reset  = 1'b0;
        reset5 = 1'b0;

        // Idle after reset: nothing until the first strobe.
        for (int n = 0; n < 100; n++) begin
            if (n % 10 == 0) begin
                check("idle_out", 32'(out), 32'd0);
                check("idle_done", 32'(done), 32'd0);
            end
            tick();
        end

        // ch0 saw period 3, ch1 triangle period 2, ch2 saw period 2 restarted at cnt=7 on a step.
        period   = {16'd2, 16'd2, 16'd3};
        shape    = {4'b1100, 4'b1110, 4'b1100};
        shape_we = 3'b111;
        tick();
        shape_we = 3'b000;
        for (int k = 0; k < 100; k++) begin
            check("saw_p3_ch0", lvl(0), 32'((k / 3) % 16));
            s = k / 2;
            check("tri_p2_ch1", lvl(1), 32'(((s / 16) % 2 == 1) ? (15 - s % 16) : (s % 16)));
            check("restart_ch2", lvl(2), 32'((k < 16) ? (k / 2) : (((k - 16) / 2) % 16)));
            check("run_done", 32'(done), 32'd0);
            if (k == 15) shape_we = 3'b100;
            if (k == 16) shape_we = 3'b000;
            tick();
        end

        // Hold shapes at period 1 on ch0/ch1, period 0 saw on ch2.
        period   = {16'd0, 16'd1, 16'd1};
        shape    = {4'b1100, 4'b0100, 4'b1011};
        shape_we = 3'b111;
        tick();
        shape_we = 3'b000;
        for (int k = 0; k < 41; k++) begin
            check("hold1011_ch0", lvl(0), 32'((k < 16) ? (15 - k) : 15));
            check("hold0100_ch1", lvl(1), 32'((k < 16) ? k : 0));
            check("per0_ch2", lvl(2), 32'(k % 16));
            check("hold_done", 32'(done), (DONE_EN && k == 16) ? 32'd3 : 32'd0);
            tick();
        end

        // Lowering ch0 period below the prescaler count steps on the next clk.
        period[15:0] = 16'd10;
        shape[3:0]   = 4'b1100;
        shape_we     = 3'b001;
        tick();
        shape_we = 3'b000;
        for (int k = 0; k < 11; k++) begin
            check("per_drop_ch0", lvl(0), (k <= 6) ? 32'd0 : ((k <= 9) ? 32'd1 : 32'd2));
            if (k == 6) period[15:0] = 16'd3;
            tick();
        end

        // Reset asserted mid-run.
        reset = 1'b1;
        tick();
        check("midreset_out", 32'(out), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        reset = 1'b0;
        for (int n = 0; n < 5; n++) tick();
        check("post_reset_out", 32'(out), 32'd0);

        // 5-bit envelope saw spans 0..31.
        period5   = 16'd1;
        shape5    = 4'b1100;
        shape_we5 = 1'b1;
        tick();
        shape_we5 = 1'b0;
        for (int k = 0; k < 41; k++) begin
            check("saw5", 32'(out5), 32'(k % 32));
            check("saw5_done", 32'(done5), 32'd0);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
